// File: rtl/ir_fetch_buffer.sv
// IF/ID instruction register: latches fetched words, assembles two-word
// instructions (opcode + immediate) and supports stall and flush.
module ir_fetch_buffer #(
  parameter int unsigned          WORD_W    = 16,
  parameter int unsigned          PC_W      = 32,
  parameter int unsigned          LONG_BIT  = 15,
  parameter logic [WORD_W-1:0]    NOP_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic              stall,
  input  logic              flush,
  input  logic [WORD_W-1:0] in,
  input  logic [PC_W-1:0]   pc_in,
  output logic [WORD_W-1:0] ir_out,
  output logic [WORD_W-1:0] imm_out,
  output logic [PC_W-1:0]   pc_out,
  output logic              valid_out,
  output logic              waiting_imm
);

  typedef enum logic {FIRST, SECOND} state_t;

  state_t            state;
  logic [WORD_W-1:0] pending_ir;
  logic [PC_W-1:0]   pending_pc;

  // Priority on each edge: flush, then stall, then a fetched word or a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FIRST;
      pending_ir <= '0;
      pending_pc <= '0;
      ir_out     <= NOP_VALUE;
      imm_out    <= '0;
      pc_out     <= '0;
      valid_out  <= 1'b0;
    end else if (flush) begin
      state      <= FIRST;
      pending_ir <= '0;
      pending_pc <= '0;
      ir_out     <= NOP_VALUE;
      imm_out    <= '0;
      valid_out  <= 1'b0;
    end else if (!stall) begin
      if (!write_enable) begin
        ir_out    <= NOP_VALUE;
        imm_out   <= '0;
        valid_out <= 1'b0;
      end else if (state == SECOND) begin
        // The immediate word is taken verbatim; its LONG_BIT means nothing here.
        ir_out    <= pending_ir;
        imm_out   <= in;
        pc_out    <= pending_pc;
        valid_out <= 1'b1;
        state     <= FIRST;
      end else if (in[LONG_BIT]) begin
        pending_ir <= in;
        pending_pc <= pc_in;
        ir_out     <= NOP_VALUE;
        imm_out    <= '0;
        valid_out  <= 1'b0;
        state      <= SECOND;
      end else begin
        ir_out    <= in;
        imm_out   <= '0;
        pc_out    <= pc_in;
        valid_out <= 1'b1;
      end
    end
  end

  assign waiting_imm = (state == SECOND);

endmodule

// File: tb/tb_ir_fetch_buffer.sv
// Directed self-checking bench for ir_fetch_buffer with hand-computed expectations.
module tb_ir_fetch_buffer;

  logic        clk;
  logic        rst;
  logic        write_enable;
  logic        stall;
  logic        flush;
  logic [15:0] in;
  logic [31:0] pc_in;
  logic [15:0] ir_out;
  logic [15:0] imm_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        waiting_imm;

  int checks   = 0;
  int failures = 0;

  ir_fetch_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .stall        (stall),
    .flush        (flush),
    .in           (in),
    .pc_in        (pc_in),
    .ir_out       (ir_out),
    .imm_out      (imm_out),
    .pc_out       (pc_out),
    .valid_out    (valid_out),
    .waiting_imm  (waiting_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge happen, then sample 1ns later.
  task automatic applyStimulus(input logic we, input logic st, input logic fl,
                               input logic [15:0] word, input logic [31:0] pc);
    write_enable = we;
    stall        = st;
    flush        = fl;
    in           = word;
    pc_in        = pc;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] exp_ir,
                             input logic [15:0] exp_imm, input logic [31:0] exp_pc,
                             input logic exp_valid, input logic exp_wait);
    checks++;
    assert ({ir_out, imm_out, pc_out, valid_out, waiting_imm} ===
            {exp_ir, exp_imm, exp_pc, exp_valid, exp_wait})
    else begin
      failures++;
      $error("[TB] FAIL %s: got ir=%h imm=%h pc=%h valid=%b wait=%b, expected ir=%h imm=%h pc=%h valid=%b wait=%b",
             tag, ir_out, imm_out, pc_out, valid_out, waiting_imm,
             exp_ir, exp_imm, exp_pc, exp_valid, exp_wait);
    end
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL timeout: simulation did not reach its end");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; write_enable = 1'b0; stall = 1'b0; flush = 1'b0;
    in = '0; pc_in = '0;
    @(posedge clk); #1;
    checkOutput("reset_initial", 16'h0000, 16'h0000, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 16'd1234, 32'h5);
    checkOutput("pre_reset_word", 16'd1234, 16'h0000, 32'h5, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle while a word is being presented.
    write_enable = 1'b1; in = 16'd1234;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_immediate", 16'h0000, 16'h0000, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd1234, 32'h6);
    checkOutput("reset_held_edge1", 16'h0000, 16'h0000, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd1234, 32'h7);
    checkOutput("reset_held_edge2", 16'h0000, 16'h0000, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;

    // Back-to-back one-word instructions.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd1234, 32'h10);
    checkOutput("one_word_a", 16'd1234, 16'h0000, 32'h10, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd9999, 32'h11);
    checkOutput("one_word_b", 16'd9999, 16'h0000, 32'h11, 1'b1, 1'b0);

    // Stall holds a valid instruction.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd1234, 32'h12);
    checkOutput("pre_stall", 16'd1234, 16'h0000, 32'h12, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 16'd9999, 32'h13);
      checkOutput("stall_hold", 16'd1234, 16'h0000, 32'h12, 1'b1, 1'b0);
    end

    // Two-word instruction: one bubble, then assembled output.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h8001, 32'h20);
    checkOutput("two_word_first", 16'h0000, 16'h0000, 32'h12, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h00AB, 32'h21);
    checkOutput("two_word_second", 16'h8001, 16'h00AB, 32'h20, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 16'h1234, 32'h99);
    checkOutput("bubble_no_write", 16'h0000, 16'h0000, 32'h20, 1'b0, 1'b0);

    // Stall and idle cycles while waiting for the immediate keep the pending word.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h8001, 32'h30);
    checkOutput("second_wait", 16'h0000, 16'h0000, 32'h20, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h1111, 32'h31);
      checkOutput("stall_in_second", 16'h0000, 16'h0000, 32'h20, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h2222, 32'h31);
    checkOutput("idle_in_second", 16'h0000, 16'h0000, 32'h20, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h80CD, 32'h32);
    checkOutput("pending_kept", 16'h8001, 16'h80CD, 32'h30, 1'b1, 1'b0);

    // Flush beats stall and discards the pending first word.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h8002, 32'h40);
    checkOutput("pre_flush_second", 16'h0000, 16'h0000, 32'h30, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h00AB, 32'h41);
    checkOutput("flush_with_stall", 16'h0000, 16'h0000, 32'h30, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0005, 32'h41);
    checkOutput("after_flush_one_word", 16'h0005, 16'h0000, 32'h41, 1'b1, 1'b0);

    // Flush of a valid instruction keeps pc_out.
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0007, 32'h60);
    checkOutput("flush_valid", 16'h0000, 16'h0000, 32'h41, 1'b0, 1'b0);

    // Reset pulse in the middle of assembly.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h8003, 32'h50);
    checkOutput("pre_reset_second", 16'h0000, 16'h0000, 32'h41, 1'b0, 1'b1);
    rst = 1'b1;
    #2;
    checkOutput("reset_mid_assembly", 16'h0000, 16'h0000, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h00AB, 32'h51);
    checkOutput("after_reset_one_word", 16'h00AB, 16'h0000, 32'h51, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
